multi_clk_divider: RTL and testbench
====================================

// Module: multi_clk_divider
// PURPOSE
//  N-channel programmable clock divider / tick generator; successor to the fixed single-channel divider.
//  Sits beside the CPU top level, fed from CLOCK_50.
//  Produces slow square waves (e.g. a slowed CPU clock, LED blink) and one-cycle tick enables.
//  Divisor and mode per channel are runtime-loadable through a simple write port; updates are glitch-free.
// PARAMETERS
//  N_CH         4         number of channels
//  CH_IDX_W     2         width of cfg_chan; must satisfy 2**CH_IDX_W >= N_CH
//  CNT_WIDTH    32        counter/divisor width
//  DEFAULT_DIV  2500000   divisor loaded into every channel at reset
// PORTS
//  clk        in   1          system clock
//  reset      in   1          asynchronous, active-low reset
//  en         in   N_CH       per-channel run enable
//  sync       in   1          synchronous restart of all channels
//  cfg_wr     in   1          config write strobe
//  cfg_chan   in   CH_IDX_W   channel to configure
//  cfg_div    in   CNT_WIDTH  new divisor
//  cfg_mode   in   1          0 = square, 1 = pulse
//  clk_out    out  N_CH       divided output (registered)
//  tick       out  N_CH       1-cycle pulse at each terminal count (registered)
//  cfg_pend   out  N_CH       shadow config waiting for the next terminal count
// BEHAVIOUR
//  - Reset (async, reset==0), per channel:
//    - cnt = 0, div_act = DEFAULT_DIV, mode_act = square
//    - clk_out = 0, tick = 0, cfg_pend = 0
//  - Enabled channel:
//    - cnt += 1 every cycle.
//    - Terminal count (TC) is cnt >= div_act. At TC: cnt <= 0 and tick <= 1 on the next edge.
//    - Square mode: clk_out toggles at TC; period = 2*(div_act+1) cycles.
//    - Pulse mode: clk_out = tick; period = div_act+1 cycles.
//    - div = 0: square mode toggles every cycle; pulse mode holds clk_out = 1.
//  - Disabled channel: cnt and clk_out hold; tick = 0.
//  - Config write, addressed channel disabled: div/mode applied on the next edge; cnt is kept.
//    The >= compare therefore terminates at once if the new div is <= cnt.
//  - Config write, addressed channel enabled: value goes to shadow and cfg_pend <= 1.
//    - Shadow is copied to div_act/mode_act in the TC cycle; cfg_pend <= 0.
//    - A write in the same cycle as TC is applied directly, with no pending state.
//    - A second write while pending overwrites the shadow.
//  - cfg_chan >= N_CH: write ignored.
//  - Mode change at apply: clk_out <= 0 in pulse mode; in square mode clk_out continues from its current level.
//  - sync (priority over TC and en):
//    - Every channel: cnt <= 0, clk_out <= 0, tick <= 0.
//    - Any pending shadow is applied and cfg_pend <= 0.
//    - A cfg_wr in the sync cycle is applied directly.
//  - cnt arithmetic is CNT_WIDTH bits, unsigned. It cannot wrap, because TC occurs at or before all-ones.
//  - Latency: outputs are registered; clk_out/tick change on the edge after the TC cycle.
// STRUCTURE
//  - Shared package / include file:
//    - MODE_SQUARE = 1'b0, MODE_PULSE = 1'b1
//    - DEFAULT_DIV
//  - Sub-module clk_div_channel: one channel holding cnt, div_act, mode_act, shadow, pend, clk_out, tick.
//    - Instantiated N_CH times with a generate loop.
//    - Top level decodes cfg_chan into per-channel write strobes and fans out sync.
// TESTING
//  1. Reset, en=4'b0001, div=2500000 -> ch0 toggles every 2500001 cycles; ticks on ch1-3 = 0.
//  2. Disabled ch1: write div=3, square; then en[1]=1 -> clk_out[1] period 8; tick every 4 cycles.
//  3. ch2 running div=9; write div=1 mid-period -> cfg_pend[2]=1.
//     -> Old period completes (10 cycles), pend clears, then 2-cycle half-periods.
//  4. ch3 pulse mode, div=4 -> tick[3]=clk_out[3] high 1 of every 5 cycles.
//     div=0 in pulse mode -> clk_out[3] held 1.
//  5. sync asserted mid-count with a pending write on ch0 -> next edge: all cnt=0, clk_out=0.
//     ch0 new div is active; first TC after exactly div+1 cycles.
//  6. Other boundaries:
//     - reset asserted mid-count -> outputs 0 immediately, with no clock edge needed.
//     - cfg_chan=5 with N_CH=4 -> no state change.
//     - write coinciding with TC -> no pend; new period applied next.

Source files
------------

// File: rtl/multi_clk_divider_pkg.sv
// Shared constants for the multi-channel clock divider: output modes and reset divisor.
package multi_clk_divider_pkg;

  localparam logic ModeSquare = 1'b0;
  localparam logic ModePulse  = 1'b1;

  localparam int unsigned DefaultDivVal = 32'd2500000;

endpackage

// File: rtl/multi_clk_divider_channel.sv
// One divider channel: counter, active and shadow config, registered clk_out and tick.
module multi_clk_divider_channel
  import multi_clk_divider_pkg::*;
#(
  parameter int unsigned CntWidth   = 32,
  parameter int unsigned DefaultDiv = DefaultDivVal
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                sync_i,
  input  logic                wr_i,
  input  logic [CntWidth-1:0] wr_div_i,
  input  logic                wr_mode_i,
  output logic                clk_out_o,
  output logic                tick_o,
  output logic                pend_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] div_q, div_d;
  logic [CntWidth-1:0] sh_div_q, sh_div_d;
  logic                mode_q, mode_d;
  logic                sh_mode_q, sh_mode_d;
  logic                pend_q, pend_d;
  logic                clk_out_q, clk_out_d;
  logic                tick_q, tick_d;
  logic                tc;

  assign tc = (cnt_q >= div_q);

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    sh_div_d  = sh_div_q;
    mode_d    = mode_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (sync_i) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      pend_d    = 1'b0;
      if (wr_i) begin
        div_d  = wr_div_i;
        mode_d = wr_mode_i;
      end else if (pend_q) begin
        div_d  = sh_div_q;
        mode_d = sh_mode_q;
      end
    end else if (!en_i) begin
      if (wr_i) begin
        div_d  = wr_div_i;
        mode_d = wr_mode_i;
        pend_d = 1'b0;
        if (wr_mode_i == ModePulse && mode_q != ModePulse) begin
          clk_out_d = 1'b0;
        end
      end
    end else if (tc) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      pend_d = 1'b0;
      if (wr_i) begin
        div_d  = wr_div_i;
        mode_d = wr_mode_i;
      end else if (pend_q) begin
        div_d  = sh_div_q;
        mode_d = sh_mode_q;
      end
      // A mode switch overrides the normal TC output behaviour for this edge.
      if (mode_d != mode_q) begin
        clk_out_d = (mode_d == ModePulse) ? 1'b0 : clk_out_q;
      end else begin
        clk_out_d = (mode_q == ModePulse) ? 1'b1 : ~clk_out_q;
      end
    end else begin
      cnt_d = cnt_q + CntWidth'(1);
      if (mode_q == ModePulse) begin
        clk_out_d = 1'b0;
      end
      if (wr_i) begin
        sh_div_d  = wr_div_i;
        sh_mode_d = wr_mode_i;
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      div_q     <= CntWidth'(DefaultDiv);
      sh_div_q  <= CntWidth'(DefaultDiv);
      mode_q    <= ModeSquare;
      sh_mode_q <= ModeSquare;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      sh_div_q  <= sh_div_d;
      mode_q    <= mode_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/multi_clk_divider.sv
// N-channel programmable clock divider / tick generator with a shared config write port.
module multi_clk_divider
  import multi_clk_divider_pkg::*;
#(
  parameter int unsigned NCh        = 4,
  parameter int unsigned ChIdxW     = 2,
  parameter int unsigned CntWidth   = 32,
  parameter int unsigned DefaultDiv = DefaultDivVal
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NCh-1:0]      en_i,
  input  logic                sync_i,
  input  logic                cfg_wr_i,
  input  logic [ChIdxW-1:0]   cfg_chan_i,
  input  logic [CntWidth-1:0] cfg_div_i,
  input  logic                cfg_mode_i,
  output logic [NCh-1:0]      clk_out_o,
  output logic [NCh-1:0]      tick_o,
  output logic [NCh-1:0]      cfg_pend_o
);

  // Out-of-range channel indices match no instance, so the write is dropped.
  for (genvar i = 0; i < NCh; i++) begin : g_ch
    multi_clk_divider_channel #(
      .CntWidth  (CntWidth),
      .DefaultDiv(DefaultDiv)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (en_i[i]),
      .sync_i   (sync_i),
      .wr_i     (cfg_wr_i && (cfg_chan_i == ChIdxW'(i))),
      .wr_div_i (cfg_div_i),
      .wr_mode_i(cfg_mode_i),
      .clk_out_o(clk_out_o[i]),
      .tick_o   (tick_o[i]),
      .pend_o   (cfg_pend_o[i])
    );
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed bench for multi_clk_divider with a per-cycle behavioural model and literal checks.
module tb_multi_clk_divider;

  localparam int unsigned NCh = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [3:0]     en_i = '0;
  logic           sync_i = 1'b0;
  logic           cfg_wr_i = 1'b0;
  logic [2:0]     cfg_chan_i = '0;
  logic [31:0]    cfg_div_i = '0;
  logic           cfg_mode_i = 1'b0;
  logic [3:0]     clk_out_o;
  logic [3:0]     tick_o;
  logic [3:0]     cfg_pend_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  multi_clk_divider #(
    .NCh     (NCh),
    .ChIdxW  (3),
    .CntWidth(32)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .sync_i    (sync_i),
    .cfg_wr_i  (cfg_wr_i),
    .cfg_chan_i(cfg_chan_i),
    .cfg_div_i (cfg_div_i),
    .cfg_mode_i(cfg_mode_i),
    .clk_out_o (clk_out_o),
    .tick_o    (tick_o),
    .cfg_pend_o(cfg_pend_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Behavioural model: what each channel's observable state is after an edge.
  typedef struct packed {
    logic [31:0] cnt;
    logic [31:0] div;
    logic [31:0] sh_div;
    logic        mode;
    logic        sh_mode;
    logic        pend;
    logic        co;
    logic        tk;
  } ch_t;

  ch_t m [NCh];

  function automatic ch_t ch_reset();
    ch_t r;
    r.cnt = 0; r.div = 32'd2500000; r.sh_div = 32'd2500000;
    r.mode = 1'b0; r.sh_mode = 1'b0; r.pend = 1'b0; r.co = 1'b0; r.tk = 1'b0;
    return r;
  endfunction

  function automatic ch_t step(ch_t s, logic en, logic sy, logic wr, logic [31:0] wd, logic wm);
    ch_t n = s;
    n.tk = 1'b0;
    if (sy) begin
      n.cnt = 0; n.co = 1'b0; n.pend = 1'b0;
      if (wr) begin n.div = wd; n.mode = wm; end
      else if (s.pend) begin n.div = s.sh_div; n.mode = s.sh_mode; end
    end else if (!en) begin
      if (wr) begin
        n.div = wd; n.mode = wm; n.pend = 1'b0;
        if (wm && !s.mode) n.co = 1'b0;
      end
    end else if (s.cnt >= s.div) begin
      n.cnt = 0; n.tk = 1'b1; n.pend = 1'b0;
      if (wr) begin n.div = wd; n.mode = wm; end
      else if (s.pend) begin n.div = s.sh_div; n.mode = s.sh_mode; end
      if (n.mode != s.mode) n.co = n.mode ? 1'b0 : s.co;
      else                  n.co = s.mode ? 1'b1 : !s.co;
    end else begin
      n.cnt = s.cnt + 1;
      if (s.mode) n.co = 1'b0;
      if (wr) begin n.sh_div = wd; n.sh_mode = wm; n.pend = 1'b1; end
    end
    return n;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NCh; i++) m[i] <= ch_reset();
    end else begin
      for (int i = 0; i < NCh; i++)
        m[i] <= step(m[i], en_i[i], sync_i, cfg_wr_i && (cfg_chan_i == 3'(i)),
                     cfg_div_i, cfg_mode_i);
    end
  end

  always @(negedge clk_i) begin
    logic [3:0] e_co, e_tk, e_pd;
    for (int i = 0; i < NCh; i++) begin
      e_co[i] = m[i].co; e_tk[i] = m[i].tk; e_pd[i] = m[i].pend;
    end
    check("model clk_out", 32'(clk_out_o), 32'(e_co));
    check("model tick", 32'(tick_o), 32'(e_tk));
    check("model cfg_pend", 32'(cfg_pend_o), 32'(e_pd));
  end

  // Caller is just past a negedge; the write is captured on the following posedge.
  task automatic wr(input logic [2:0] ch, input logic [31:0] d, input logic md);
    cfg_wr_i = 1'b1; cfg_chan_i = ch; cfg_div_i = d; cfg_mode_i = md;
    @(negedge clk_i);
    cfg_wr_i = 1'b0;
  endtask

  function automatic logic sig(input int ch, input bit use_tick);
    return use_tick ? tick_o[ch] : clk_out_o[ch];
  endfunction

  task automatic wait_rise(input int ch, input bit use_tick, input string name);
    logic prev = sig(ch, use_tick);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_i);
      if (sig(ch, use_tick) && !prev) return;
      prev = sig(ch, use_tick);
    end
    check({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic measure_period(input int ch, input bit use_tick, input int exp,
                                input string name);
    logic prev = sig(ch, use_tick);
    int first = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_i);
      if (sig(ch, use_tick) && !prev) begin
        if (first < 0) first = t;
        else begin
          check(name, 32'(t - first), 32'(exp));
          return;
        end
      end
      prev = sig(ch, use_tick);
    end
    check({name, " timeout"}, 32'hffff_ffff, 32'(exp));
  endtask

  initial begin
    int t0, highs, k;
    #2;
    check("reset clk_out", 32'(clk_out_o), 32'd0);
    check("reset tick", 32'(tick_o), 32'd0);
    check("reset pend", 32'(cfg_pend_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    en_i = 4'b0001;

    // Default divisor: nothing can toggle for 2.5M cycles.
    repeat (50) @(negedge clk_i);
    check("default div no toggle", 32'(clk_out_o), 32'd0);
    check("default div no tick", 32'(tick_o), 32'd0);

    // Disabled channel configured, then enabled.
    wr(3'd1, 32'd3, 1'b0);
    en_i[1] = 1'b1;
    measure_period(1, 1'b1, 4, "ch1 tick period");
    measure_period(1, 1'b0, 8, "ch1 clk_out period");

    // Out-of-range channel must not touch ch1 (which shares the low index bits).
    wr(3'd5, 32'd0, 1'b1);
    check("chan5 no pend", 32'(cfg_pend_o), 32'd0);
    measure_period(1, 1'b0, 8, "ch1 period after chan5");

    // Running channel: mid-period write is shadowed until the old period ends.
    wr(3'd2, 32'd9, 1'b0);
    en_i[2] = 1'b1;
    wait_rise(2, 1'b1, "ch2 first tick");
    t0 = cyc;
    repeat (3) @(negedge clk_i);
    wr(3'd2, 32'd1, 1'b0);
    check("ch2 pend set", 32'(cfg_pend_o[2]), 32'd1);
    wait_rise(2, 1'b1, "ch2 old period tick");
    check("ch2 old period length", 32'(cyc - t0), 32'd10);
    check("ch2 pend cleared", 32'(cfg_pend_o[2]), 32'd0);
    measure_period(2, 1'b0, 4, "ch2 new clk_out period");

    // Pulse mode.
    wr(3'd3, 32'd4, 1'b1);
    en_i[3] = 1'b1;
    measure_period(3, 1'b1, 5, "ch3 pulse tick period");
    measure_period(3, 1'b0, 5, "ch3 pulse clk_out period");
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      highs += int'(clk_out_o[3]);
    end
    check("ch3 highs in 20", 32'(highs), 32'd4);
    wr(3'd3, 32'd0, 1'b1);
    repeat (8) @(negedge clk_i);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      highs += int'(clk_out_o[3]);
    end
    check("ch3 div0 pulse held", 32'(highs), 32'd10);

    // sync with a pending write on ch0.
    wr(3'd0, 32'd5, 1'b0);
    check("ch0 pend before sync", 32'(cfg_pend_o[0]), 32'd1);
    sync_i = 1'b1;
    @(negedge clk_i);
    sync_i = 1'b0;
    check("sync clk_out", 32'(clk_out_o), 32'd0);
    check("sync tick", 32'(tick_o), 32'd0);
    check("sync pend", 32'(cfg_pend_o), 32'd0);
    k = 0;
    while (!tick_o[0] && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    check("ch0 first tc after sync", 32'(k), 32'd6);

    // Write landing exactly in ch1's TC cycle.
    wait_rise(1, 1'b1, "ch1 tick before tc write");
    repeat (3) @(negedge clk_i);
    wr(3'd1, 32'd1, 1'b0);
    check("tc write tick", 32'(tick_o[1]), 32'd1);
    check("tc write no pend", 32'(cfg_pend_o[1]), 32'd0);
    measure_period(1, 1'b1, 2, "ch1 tick period after tc write");

    // Asynchronous reset mid-count.
    @(negedge clk_i);
    check("ch3 high before reset", 32'(clk_out_o[3]), 32'd1);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("async reset clk_out", 32'(clk_out_o), 32'd0);
    check("async reset tick", 32'(tick_o), 32'd0);
    check("async reset pend", 32'(cfg_pend_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
